// File: rtl/resp_store.sv
// resp_store: captures learned complex response samples, then streams them out.
// Define RESP_PEAK_TRACK_EN to build peak |re|+|im| tracking.
module resp_store #(
    parameter int DEPTH = 2752,
    parameter int AW    = 12
) (
    input  logic                 clk_1_6384m,
    input  logic                 rst,
    input  logic                 learn_en,
    input  logic                 learn_done,
    input  logic                 wr_en,
    input  logic signed [15:0]   wr_real,
    input  logic signed [15:0]   wr_imag,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 stream_start,
    input  logic                 m_ready,
    output logic                 m_valid,
    output logic signed [15:0]   m_real,
    output logic signed [15:0]   m_imag,
    output logic [AW-1:0]        m_addr,
    output logic                 m_last,
    output logic                 buf_ready,
    output logic [AW:0]          entry_cnt,
    output logic                 overflow,
    output logic [AW-1:0]        peak_addr,
    output logic [16:0]          peak_mag
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_STREAM  = 2'd3;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [31:0]        mem [DEPTH];

    logic [1:0]         state_q, state_d;
    logic               wr_en_q, learn_en_q, learn_done_q;
    logic               wr_rise, learn_rise, done_rise;
    logic               wr_ok, in_range, mem_we;
    logic [AW:0]        addr_p1;
    logic [AW:0]        entry_cnt_q;
    logic               overflow_q, buf_ready_q;
    logic               rd_pend_q;
    logic [AW-1:0]      rd_ptr_q;
    logic               rd_is_last;
    logic               m_valid_q, m_last_q;
    logic [AW-1:0]      m_addr_q;
    logic signed [15:0] m_real_q, m_imag_q;
    logic               hs, stream_go;

    assign wr_rise    = wr_en & ~wr_en_q;
    assign learn_rise = learn_en & ~learn_en_q;
    assign done_rise  = learn_done & ~learn_done_q;

    // A learn_en rise restarts capture, so a write in that same cycle is dropped.
    assign wr_ok      = wr_rise & ~learn_rise & (state_q == S_CAPTURE);
    assign in_range   = ({1'b0, wr_addr} < DEPTH_W);
    assign mem_we     = wr_ok & in_range;
    assign addr_p1    = (AW+1)'(wr_addr) + (AW+1)'(1);

    assign hs         = m_valid_q & m_ready;
    assign stream_go  = (state_q == S_DONE) & stream_start & (entry_cnt_q != '0);
    assign rd_is_last = ((AW+1)'(rd_ptr_q) + (AW+1)'(1)) == entry_cnt_q;

    always_comb begin
        state_d = state_q;
        if (learn_rise) begin
            state_d = S_CAPTURE;
        end else begin
            unique case (state_q)
                S_IDLE:    state_d = S_IDLE;
                S_CAPTURE: if (done_rise) state_d = S_DONE;
                S_DONE:    if (stream_go) state_d = S_STREAM;
                S_STREAM:  if (hs && m_last_q) state_d = S_DONE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1_6384m) begin
        if (mem_we) begin
            mem[wr_addr] <= {wr_real, wr_imag};
        end
    end

    always_ff @(posedge clk_1_6384m or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_en_q      <= 1'b0;
            learn_en_q   <= 1'b0;
            learn_done_q <= 1'b1;
            entry_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            buf_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en;
            learn_en_q   <= learn_en;
            learn_done_q <= learn_done;
            if (learn_rise) begin
                entry_cnt_q <= '0;
                overflow_q  <= 1'b0;
                buf_ready_q <= 1'b0;
            end else begin
                if (wr_ok && !in_range) begin
                    overflow_q <= 1'b1;
                end
                if (mem_we && (addr_p1 > entry_cnt_q)) begin
                    entry_cnt_q <= addr_p1;
                end
                if ((state_q == S_CAPTURE) && done_rise) begin
                    buf_ready_q <= 1'b1;
                end
            end
        end
    end

    // One read in flight at a time: issue, present, handshake, then a bubble.
    always_ff @(posedge clk_1_6384m or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_ptr_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_addr_q  <= '0;
            m_real_q  <= '0;
            m_imag_q  <= '0;
        end else if (learn_rise) begin
            rd_pend_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (stream_go) begin
            rd_pend_q <= 1'b1;
            rd_ptr_q  <= '0;
        end else if (rd_pend_q) begin
            rd_pend_q            <= 1'b0;
            m_valid_q            <= 1'b1;
            m_addr_q             <= rd_ptr_q;
            m_last_q             <= rd_is_last;
            {m_real_q, m_imag_q} <= mem[rd_ptr_q];
        end else if (hs) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (!m_last_q) begin
                rd_pend_q <= 1'b1;
                rd_ptr_q  <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_addr    = m_addr_q;
    assign m_real    = m_real_q;
    assign m_imag    = m_imag_q;
    assign buf_ready = buf_ready_q;
    assign entry_cnt = entry_cnt_q;
    assign overflow  = overflow_q;

`ifdef RESP_PEAK_TRACK_EN
    logic [16:0]   re_x, im_x, abs_re, abs_im, mag;
    logic [16:0]   peak_mag_q;
    logic [AW-1:0] peak_addr_q;

    always_comb begin
        re_x   = {wr_real[15], wr_real};
        im_x   = {wr_imag[15], wr_imag};
        abs_re = re_x[16] ? (~re_x + 17'd1) : re_x;
        abs_im = im_x[16] ? (~im_x + 17'd1) : im_x;
        mag    = abs_re + abs_im;
    end

    always_ff @(posedge clk_1_6384m or posedge rst) begin
        if (rst) begin
            peak_mag_q  <= '0;
            peak_addr_q <= '0;
        end else if (learn_rise) begin
            peak_mag_q  <= '0;
            peak_addr_q <= '0;
        end else if (mem_we && (mag > peak_mag_q)) begin
            peak_mag_q  <= mag;
            peak_addr_q <= wr_addr;
        end
    end

    assign peak_mag  = peak_mag_q;
    assign peak_addr = peak_addr_q;
`else
    assign peak_mag  = '0;
    assign peak_addr = '0;
`endif

endmodule

// File: tb/tb_resp_store.sv
// tb_resp_store: random and directed capture/stream traffic, scoreboard-checked
// against a memory-level reference model of the response buffer.
module tb_resp_store;
    localparam int DEPTH = 2752;
    localparam int AW    = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic               learn_en, learn_done, wr_en, stream_start, m_ready;
    logic signed [15:0] wr_real, wr_imag, m_real, m_imag;
    logic [AW-1:0]      wr_addr, m_addr, peak_addr;
    logic               m_valid, m_last, buf_ready, overflow;
    logic [AW:0]        entry_cnt;
    logic [16:0]        peak_mag;

    resp_store #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_1_6384m(clk), .rst(rst),
        .learn_en(learn_en), .learn_done(learn_done),
        .wr_en(wr_en), .wr_real(wr_real), .wr_imag(wr_imag), .wr_addr(wr_addr),
        .stream_start(stream_start), .m_ready(m_ready),
        .m_valid(m_valid), .m_real(m_real), .m_imag(m_imag),
        .m_addr(m_addr), .m_last(m_last), .buf_ready(buf_ready),
        .entry_cnt(entry_cnt), .overflow(overflow),
        .peak_addr(peak_addr), .peak_mag(peak_mag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int      addr;
        shortint re;
        shortint im;
        bit      last;
        bit      known;
    } word_t;

    word_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];
    bit          ref_cap, ref_ready, ref_ovf;
    int          ref_cnt, ref_pk_mag, ref_pk_addr;

    int          rdy_mode  = 0;
    int          stall_cnt = 0;
    bit          hs_prev   = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            2: if (m_valid && m_addr == 2 && stall_cnt < 5) begin
                   m_ready = 1'b0;
                   stall_cnt++;
               end else begin
                   m_ready = 1'b1;
               end
            default: m_ready = !(m_valid && m_addr == 1);
        endcase
    end

    // Monitor: every presented word must equal the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (hs_prev) chk("bubble_after_hs", m_valid, 0);
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual_addr=%0d required=none", m_addr);
                end else begin
                    chk("m_addr", m_addr, exp_q[0].addr);
                    chk("m_last", m_last, exp_q[0].last);
                    if (exp_q[0].known) begin
                        chk("m_real", m_real, exp_q[0].re);
                        chk("m_imag", m_imag, exp_q[0].im);
                    end
                    if (m_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("m_last_idle", m_last, 0);
            end
            hs_prev = m_valid && m_ready;
        end
    end

    task automatic learn_start();
        learn_en   = 1'b1;
        learn_done = 1'b0;
        tick();
        ref_cap     = 1'b1;
        ref_ready   = 1'b0;
        ref_cnt     = 0;
        ref_ovf     = 1'b0;
        ref_pk_mag  = 0;
        ref_pk_addr = 0;
    endtask

    task automatic learn_finish();
        learn_en   = 1'b0;
        learn_done = 1'b1;
        tick();
        ref_cap   = 1'b0;
        ref_ready = 1'b1;
    endtask

    task automatic wr(input int addr, input shortint re, input shortint im);
        int mag;
        wr_en   = 1'b1;
        wr_addr = addr[AW-1:0];
        wr_real = re;
        wr_imag = im;
        tick();
        wr_en = 1'b0;
        tick();
        if (ref_cap) begin
            if (addr >= DEPTH) begin
                ref_ovf = 1'b1;
            end else begin
                ref_mem[addr]   = {re, im};
                ref_known[addr] = 1'b1;
                if (addr + 1 > ref_cnt) ref_cnt = addr + 1;
                mag = (re < 0 ? -int'(re) : int'(re)) + (im < 0 ? -int'(im) : int'(im));
`ifdef RESP_PEAK_TRACK_EN
                if (mag > ref_pk_mag) begin
                    ref_pk_mag  = mag;
                    ref_pk_addr = addr;
                end
`endif
            end
        end
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        chk({tag, "_buf_ready"}, buf_ready, ref_ready);
        chk({tag, "_entry_cnt"}, entry_cnt, ref_cnt);
        chk({tag, "_overflow"}, overflow, ref_ovf);
        chk({tag, "_peak_mag"}, peak_mag, ref_pk_mag);
        chk({tag, "_peak_addr"}, peak_addr, ref_pk_addr);
    endtask

    task automatic push_words();
        word_t w;
        for (int a = 0; a < ref_cnt; a++) begin
            w.addr  = a;
            w.re    = shortint'(ref_mem[a][31:16]);
            w.im    = shortint'(ref_mem[a][15:0]);
            w.last  = (a == ref_cnt - 1);
            w.known = ref_known[a];
            exp_q.push_back(w);
        end
    endtask

    task automatic do_stream(input int mode);
        int bound;
        rdy_mode     = mode;
        stall_cnt    = 0;
        stream_start = 1'b1;
        push_words();
        tick();
        stream_start = 1'b0;
        @(negedge clk);
        chk("lat_t1_valid", m_valid, 0);
        @(negedge clk);
        chk("lat_t2_valid", m_valid, 1);
        chk("lat_t2_addr", m_addr, 0);
        bound = 8 * ref_cnt + 40;
        for (int c = 0; c < bound && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout actual_left=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        chk("end_valid", m_valid, 0);
        chk("end_buf_ready", buf_ready, 1);
        tick();
        rdy_mode = 0;
    endtask

    initial begin
        int n, addr;
        bit found;
        rst = 1'b1; learn_en = 1'b0; learn_done = 1'b1; wr_en = 1'b0;
        wr_real = '0; wr_imag = '0; wr_addr = '0; stream_start = 1'b0; m_ready = 1'b1;
        ref_cap = 0; ref_ready = 0; ref_ovf = 0; ref_cnt = 0; ref_pk_mag = 0; ref_pk_addr = 0;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_real", m_real, 0);
        chk("rst_m_imag", m_imag, 0);
        chk("rst_m_addr", m_addr, 0);
        check_status("rst");
        tick();

        learn_start();
        for (int i = 0; i < 4; i++) wr(i, shortint'(100 * i), shortint'(-50 * i));
        learn_finish();
        check_status("basic");
        tick();
        do_stream(0);
        do_stream(2);
        chk("stall_cycles", stall_cnt, 5);

        learn_start();
        for (int i = 0; i < 4; i++) wr(i, shortint'(100 * i), shortint'(-50 * i));
        wr(DEPTH, 16'sd7, 16'sd7);
        check_status("ovf_mid");
        learn_finish();
        check_status("ovf_done");
        learn_start();
        check_status("ovf_clear");
        for (int i = 0; i < 4; i++) wr(i, shortint'(100 * i), shortint'(-50 * i));
        learn_finish();

        wr(10, 16'sd1, 16'sd1);
        check_status("wr_outside");
        rdy_mode     = 3;
        stream_start = 1'b1;
        push_words();
        tick();
        stream_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (m_valid && m_addr == 1) found = 1'b1;
            else tick();
        end
        chk("abort_reached_addr1", found, 1);
        learn_en   = 1'b1;
        learn_done = 1'b0;
        tick();
        exp_q.delete();
        ref_cap = 1; ref_ready = 0; ref_cnt = 0; ref_ovf = 0; ref_pk_mag = 0; ref_pk_addr = 0;
        @(negedge clk);
        chk("abort_m_valid", m_valid, 0);
        check_status("abort");
        rdy_mode = 0;
        learn_finish();
        check_status("empty_done");
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("empty_no_stream", m_valid, 0);
        end
        tick();

        learn_start();
        wr(5, 16'sd3, -16'sd4);
        wr(9, -16'sd32768, 16'sd0);
        wr(12, 16'sd32767, 16'sd1);
        learn_finish();
        check_status("peak");
        tick();
        do_stream(1);

        for (int it = 0; it < 6; it++) begin
            learn_start();
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 7) == 0) addr = $urandom_range(DEPTH, 4095);
                else addr = $urandom_range(0, 31);
                if ($urandom_range(0, 9) == 0) wr(addr, -16'sd32768, shortint'($urandom));
                else wr(addr, shortint'($urandom), shortint'($urandom));
            end
            learn_finish();
            check_status("rand");
            tick();
            if (ref_cnt > 0) do_stream($urandom_range(0, 1));
        end

        learn_start();
        wr(DEPTH - 1, 16'sd1234, -16'sd4321);
        learn_finish();
        check_status("top_addr");
        tick();
        do_stream(0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_ready = 0; ref_cnt = 0; ref_ovf = 0; ref_pk_mag = 0; ref_pk_addr = 0;
        check_status("mid_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end
endmodule
